// File: rtl/hdc_search_pkg.sv
// Shared types and defaults for the class hypervector search stage.
// Provides the FSM state enum, default sizes and a distance-width helper.
package hdc_search_pkg;

  typedef enum logic [1:0] {
    LOAD,
    SEARCH,
    DRAIN,
    DONE
  } search_state_t;

  localparam int N_CLASSES = 8;
  localparam int N_FRAMES  = 3;

  // Bits needed to hold a full-hypervector Hamming distance.
  function automatic int dist_w(input int n_frames, input int w);
    return $clog2(n_frames * w + 1);
  endfunction

endpackage

// File: rtl/hvec_popcount.sv
// Combinational population count built as a recursive adder tree.
// Ports: vec (W bits) in, cnt ($clog2(W+1) bits) out.
module hvec_popcount #(
  parameter int W  = 64,
  parameter int OW = $clog2(W + 1)
) (
  input  logic [W-1:0]  vec,
  output logic [OW-1:0] cnt
);

  generate
    if (W == 1) begin : g_leaf
      assign cnt = vec;
    end else begin : g_node
      localparam int WL = W / 2;
      localparam int WH = W - WL;
      localparam int OL = $clog2(WL + 1);
      localparam int OH = $clog2(WH + 1);

      logic [OL-1:0] cnt_lo;
      logic [OH-1:0] cnt_hi;

      hvec_popcount #(.W(WL)) u_lo (
        .vec (vec[WL-1:0]),
        .cnt (cnt_lo)
      );

      hvec_popcount #(.W(WH)) u_hi (
        .vec (vec[W-1:WL]),
        .cnt (cnt_hi)
      );

      assign cnt = OW'(cnt_lo) + OW'(cnt_hi);
    end
  endgenerate

endmodule

// File: rtl/class_hvec_search.sv
// Buffers one query hypervector, sweeps all class frames from the generator
// and returns the minimum-Hamming-distance class over a valid/ready port.
// Ports: clk/rst, q_valid/q_ready/q_data query in, frame_id/frame_index
// address out, class_vec_in generator data, res_* result out, busy status.
module class_hvec_search #(
  parameter int DI_PARALLEL_W_BITS = 64,
  parameter int N_CLASSES          = hdc_search_pkg::N_CLASSES,
  parameter int N_FRAMES           = hdc_search_pkg::N_FRAMES,
  parameter int CLASS_ID_W         = 3,
  parameter int FRAME_IDX_W        = 2,
  parameter int DIST_W             = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          q_valid,
  output logic                          q_ready,
  input  logic [DI_PARALLEL_W_BITS-1:0] q_data,
  output logic [CLASS_ID_W-1:0]         frame_id,
  output logic [FRAME_IDX_W-1:0]        frame_index,
  input  logic [DI_PARALLEL_W_BITS-1:0] class_vec_in,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [CLASS_ID_W-1:0]         res_class,
  output logic [DIST_W-1:0]             res_dist,
  output logic                          busy
);

  import hdc_search_pkg::*;

  localparam int W    = DI_PARALLEL_W_BITS;
  localparam int PC_W = $clog2(W + 1);
  localparam logic [FRAME_IDX_W-1:0] F_LAST = FRAME_IDX_W'(N_FRAMES - 1);
  localparam logic [CLASS_ID_W-1:0]  C_LAST = CLASS_ID_W'(N_CLASSES - 1);

  search_state_t state_q, state_d;

  logic [W-1:0]           qbuf_q [N_FRAMES];
  logic [W-1:0]           qbuf_d [N_FRAMES];
  logic [FRAME_IDX_W-1:0] ld_q, ld_d;
  logic [CLASS_ID_W-1:0]  c_q, c_d;
  logic [FRAME_IDX_W-1:0] f_q, f_d;

  logic                   s1_vld_q, s1_vld_d;
  logic [PC_W-1:0]        s1_pc_q, s1_pc_d;
  logic [CLASS_ID_W-1:0]  s1_cls_q, s1_cls_d;
  logic                   s1_last_q, s1_last_d;

  logic [DIST_W-1:0]      acc_q, acc_d;
  logic [DIST_W-1:0]      best_dist_q, best_dist_d;
  logic [CLASS_ID_W-1:0]  best_cls_q, best_cls_d;

  logic [PC_W-1:0]        pc;
  logic [DIST_W-1:0]      sum;

  hvec_popcount #(.W(W)) u_pc (
    .vec (qbuf_q[f_q] ^ class_vec_in),
    .cnt (pc)
  );

  assign sum         = acc_q + DIST_W'(s1_pc_q);
  assign q_ready     = (state_q == LOAD) && !rst;
  assign busy        = (state_q == SEARCH) || (state_q == DRAIN);
  assign res_valid   = (state_q == DONE);
  assign res_class   = best_cls_q;
  assign res_dist    = best_dist_q;
  assign frame_id    = (state_q == SEARCH) ? c_q : '0;
  assign frame_index = (state_q == SEARCH) ? f_q : '0;

  always_comb begin
    state_d     = state_q;
    qbuf_d      = qbuf_q;
    ld_d        = ld_q;
    c_d         = c_q;
    f_d         = f_q;
    s1_vld_d    = (state_q == SEARCH);
    s1_pc_d     = pc;
    s1_cls_d    = c_q;
    s1_last_d   = (f_q == F_LAST);
    acc_d       = acc_q;
    best_dist_d = best_dist_q;
    best_cls_d  = best_cls_q;

    // Stage 2: accumulate per class; class 0 seeds best, strict < keeps
    // the lowest index on ties.
    if (s1_vld_q) begin
      if (s1_last_q) begin
        acc_d = '0;
        if (s1_cls_q == '0 || sum < best_dist_q) begin
          best_dist_d = sum;
          best_cls_d  = s1_cls_q;
        end
      end else begin
        acc_d = sum;
      end
    end

    unique case (state_q)
      LOAD: begin
        if (q_valid) begin
          qbuf_d[ld_q] = q_data;
          if (ld_q == F_LAST) begin
            ld_d        = '0;
            c_d         = '0;
            f_d         = '0;
            acc_d       = '0;
            best_dist_d = '0;
            best_cls_d  = '0;
            state_d     = SEARCH;
          end else begin
            ld_d = ld_q + 1'b1;
          end
        end
      end
      SEARCH: begin
        if (f_q == F_LAST) begin
          f_d = '0;
          if (c_q == C_LAST) begin
            c_d     = '0;
            state_d = DRAIN;
          end else begin
            c_d = c_q + 1'b1;
          end
        end else begin
          f_d = f_q + 1'b1;
        end
      end
      DRAIN: state_d = DONE;
      DONE: begin
        if (res_ready) state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LOAD;
      for (int i = 0; i < N_FRAMES; i++) qbuf_q[i] <= '0;
      ld_q        <= '0;
      c_q         <= '0;
      f_q         <= '0;
      s1_vld_q    <= 1'b0;
      s1_pc_q     <= '0;
      s1_cls_q    <= '0;
      s1_last_q   <= 1'b0;
      acc_q       <= '0;
      best_dist_q <= '0;
      best_cls_q  <= '0;
    end else begin
      state_q     <= state_d;
      qbuf_q      <= qbuf_d;
      ld_q        <= ld_d;
      c_q         <= c_d;
      f_q         <= f_d;
      s1_vld_q    <= s1_vld_d;
      s1_pc_q     <= s1_pc_d;
      s1_cls_q    <= s1_cls_d;
      s1_last_q   <= s1_last_d;
      acc_q       <= acc_d;
      best_dist_q <= best_dist_d;
      best_cls_q  <= best_cls_d;
    end
  end

endmodule

// File: tb/tb_class_hvec_search.sv
// Self-checking bench for class_hvec_search with a ROM generator stub.
// Expected results come from a direct min-distance search over the ROM.
module tb_class_hvec_search;

  logic        clk = 1'b0;
  logic        rst;
  logic        q_valid;
  logic        q_ready;
  logic [63:0] q_data;
  logic [2:0]  frame_id;
  logic [1:0]  frame_index;
  logic [63:0] class_vec_in;
  logic        res_valid;
  logic        res_ready;
  logic [2:0]  res_class;
  logic [7:0]  res_dist;
  logic        busy;

  int checks = 0;
  int failures = 0;

  logic [63:0] rom [0:7][0:3];
  logic [63:0] qv [3];

  always #5 clk = ~clk;

  assign class_vec_in = rom[frame_id][frame_index];

  class_hvec_search dut (
    .clk          (clk),
    .rst          (rst),
    .q_valid      (q_valid),
    .q_ready      (q_ready),
    .q_data       (q_data),
    .frame_id     (frame_id),
    .frame_index  (frame_index),
    .class_vec_in (class_vec_in),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_class    (res_class),
    .res_dist     (res_dist),
    .busy         (busy)
  );

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic set_stub_rom();
    for (int c = 0; c < 8; c++)
      for (int f = 0; f < 4; f++)
        rom[c][f] = (c == 5) ? '1 : '0;
  endtask

  task automatic set_random_rom();
    for (int c = 0; c < 8; c++)
      for (int f = 0; f < 4; f++)
        rom[c][f] = (f < 3) ? rnd64() : '0;
  endtask

  task automatic model(output int ec, output int ed);
    int d;
    ec = 0;
    ed = 0;
    for (int c = 0; c < 8; c++) begin
      d = 0;
      for (int f = 0; f < 3; f++) d += $countones(qv[f] ^ rom[c][f]);
      if (c == 0 || d < ed) begin
        ec = c;
        ed = d;
      end
    end
  endtask

  task automatic load_query(input bit gaps);
    int i = 0;
    int guard = 0;
    bit tog = 1'b0;
    while (i < 3 && guard < 50) begin
      @(negedge clk);
      guard++;
      if (gaps && tog) begin
        q_valid = 1'b0;
        q_data  = rnd64();
      end else begin
        q_valid = 1'b1;
        q_data  = qv[i];
        if (q_ready) i++;
      end
      tog = ~tog;
    end
    checks++;
    if (i != 3) begin
      failures++;
      $display("FAIL load_timeout beats=%0d required=3", i);
    end
  endtask

  task automatic wait_result(input int ec, input int ed);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        q_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || q_ready !== 1'b0 || frame_id !== 3'd0 ||
            frame_index !== 2'd0) begin
          failures++;
          $display("FAIL search_start busy=%b q_ready=%b id=%0d idx=%0d required 1 0 0 0",
                   busy, q_ready, frame_id, frame_index);
        end
      end
      if (n == 4) begin
        checks++;
        if (frame_id !== 3'd1 || frame_index !== 2'd0) begin
          failures++;
          $display("FAIL addr_wrap id=%0d idx=%0d required 1 0",
                   frame_id, frame_index);
        end
      end
    end while (!res_valid && n < 100);
    checks++;
    if (n != 26) begin
      failures++;
      $display("FAIL latency cycles=%0d required=26", n);
    end
    checks++;
    if (res_class !== 3'(ec) || res_dist !== 8'(ed) || busy !== 1'b0) begin
      failures++;
      $display("FAIL result class=%0d dist=%0d busy=%b required class=%0d dist=%0d busy=0",
               res_class, res_dist, busy, ec, ed);
    end
  endtask

  task automatic consume();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    checks++;
    if (res_valid !== 1'b0 || q_ready !== 1'b1) begin
      failures++;
      $display("FAIL consume res_valid=%b q_ready=%b required 0 1",
               res_valid, q_ready);
    end
  endtask

  task automatic run_query(input bit gaps);
    int ec, ed;
    model(ec, ed);
    load_query(gaps);
    wait_result(ec, ed);
    consume();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    q_valid = 1'b0;
    q_data = '0;
    res_ready = 1'b0;
    set_stub_rom();
    repeat (3) @(negedge clk);
    checks++;
    if (q_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_q_ready_in_rst q_ready=%b required=0", q_ready);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (q_ready !== 1'b1 || res_valid !== 1'b0 || res_class !== 3'd0 ||
        res_dist !== 8'd0 || frame_id !== 3'd0 || frame_index !== 2'd0 ||
        busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_state q_ready=%b res_valid=%b cls=%0d dist=%0d id=%0d idx=%0d busy=%b required 1 0 0 0 0 0 0",
               q_ready, res_valid, res_class, res_dist, frame_id,
               frame_index, busy);
    end
  endtask

  task automatic test_stub_patterns();
    set_stub_rom();
    for (int f = 0; f < 3; f++) qv[f] = '1;
    run_query(1'b0);
    for (int f = 0; f < 3; f++) qv[f] = '0;
    run_query(1'b0);
    for (int f = 0; f < 3; f++) qv[f] = 64'h3FF;
    run_query(1'b0);
  endtask

  task automatic test_hold();
    int ec, ed;
    set_stub_rom();
    for (int f = 0; f < 3; f++) qv[f] = rnd64();
    model(ec, ed);
    load_query(1'b0);
    wait_result(ec, ed);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      q_valid = 1'($urandom_range(0, 1));
      q_data  = rnd64();
      checks++;
      if (res_valid !== 1'b1 || res_class !== 3'(ec) ||
          res_dist !== 8'(ed) || q_ready !== 1'b0) begin
        failures++;
        $display("FAIL hold res_valid=%b cls=%0d dist=%0d q_ready=%b required 1 %0d %0d 0",
                 res_valid, res_class, res_dist, q_ready, ec, ed);
      end
    end
    q_valid = 1'b0;
    consume();
    for (int f = 0; f < 3; f++) qv[f] = '1;
    run_query(1'b0);
  endtask

  task automatic test_reset_mid();
    set_stub_rom();
    for (int f = 0; f < 3; f++) qv[f] = '1;
    load_query(1'b0);
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      q_valid = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || res_valid !== 1'b0 || q_ready !== 1'b1 ||
        frame_id !== 3'd0 || res_dist !== 8'd0 || res_class !== 3'd0) begin
      failures++;
      $display("FAIL reset_mid busy=%b res_valid=%b q_ready=%b id=%0d cls=%0d dist=%0d required 0 0 1 0 0 0",
               busy, res_valid, q_ready, frame_id, res_class, res_dist);
    end
    run_query(1'b0);
  endtask

  task automatic test_gapped_load();
    set_stub_rom();
    for (int f = 0; f < 3; f++) qv[f] = rnd64();
    qv[1] = ~qv[1];
    run_query(1'b1);
  endtask

  task automatic test_random();
    int k, a, b;
    for (int it = 0; it < 6; it++) begin
      set_random_rom();
      if (it % 2 == 1) begin
        a = $urandom_range(0, 3);
        b = $urandom_range(4, 7);
        for (int f = 0; f < 3; f++) rom[b][f] = rom[a][f];
        k = b;
      end else begin
        k = $urandom_range(0, 7);
      end
      for (int f = 0; f < 3; f++)
        qv[f] = rom[k][f] ^ (64'd1 << $urandom_range(0, 63));
      run_query(it % 3 == 2);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stub_patterns();
    test_hold();
    test_reset_mid();
    test_gapped_load();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
